// File: rtl/cpu_pkg.sv
// Shared widths and types for the 24-bit CPU datapath.
package cpu_pkg;

    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage : cpu_pkg

// File: rtl/register_file.sv
// 16 x 24-bit register file: two combinational read ports, one synchronous write port, R0 reads zero.
module register_file
    import cpu_pkg::*;
(
    input  logic              Clock,
    input  logic              ResetN,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadRS,
    output logic [DATA_W-1:0] ReadRT
);

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];

    // NOTE: always_comb uses blocking '=' with the hold value assigned first, so no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (RD != ZERO_REG)) begin
            regs_d[RD] = WriteData;
        end
        regs_d[ZERO_REG] = '0;
    end

    // NOTE: the array is plain flops, not RAM, so every entry takes the async reset.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Entry 0 is never written, so the read muxes need no special case for it.
    assign ReadRS = regs_q[RS];
    assign ReadRT = regs_q[RT];

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table, directed corner sequences, random vs. array model.
module tb_register_file;
    import cpu_pkg::*;

    logic              Clock;
    logic              ResetN;
    logic [ADDR_W-1:0] RS, RT, RD;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [DATA_W-1:0] ReadRS, ReadRT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] model [NUM_REGS];

    register_file dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .RS        (RS),
        .RT        (RT),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [ADDR_W-1:0] rs, rt, rd;
        logic [DATA_W-1:0] wd;
        logic              we;
        logic [DATA_W-1:0] exp_rs, exp_rt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs sampled 2 time units later.
    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        #3;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        step();
        ResetN = 1'b1;
    endtask

    task automatic drive(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                         input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] wd, input logic we);
        RS = rs; RT = rt; RD = rd; WriteData = wd; RegWrite = we;
    endtask

    initial begin
        logic [DATA_W-1:0] e;
        ResetN = 1'b0;
        drive('0, '0, '0, '0, 1'b0);

        // Table: reads are checked before the edge, then the write (if any) is clocked in.
        vecs[0] = '{rs: 4'd8,  rt: 4'd9,  rd: 4'd8,  wd: 24'h000005, we: 1'b1, exp_rs: 24'h000000, exp_rt: 24'h000000};
        vecs[1] = '{rs: 4'd8,  rt: 4'd9,  rd: 4'd9,  wd: 24'h000007, we: 1'b1, exp_rs: 24'h000005, exp_rt: 24'h000000};
        vecs[2] = '{rs: 4'd8,  rt: 4'd9,  rd: 4'd3,  wd: 24'hABCDEF, we: 1'b0, exp_rs: 24'h000005, exp_rt: 24'h000007};
        vecs[3] = '{rs: 4'd3,  rt: 4'd0,  rd: 4'd0,  wd: 24'hFFFFFF, we: 1'b1, exp_rs: 24'h000000, exp_rt: 24'h000000};
        vecs[4] = '{rs: 4'd0,  rt: 4'd15, rd: 4'd15, wd: 24'hFFFFFF, we: 1'b1, exp_rs: 24'h000000, exp_rt: 24'h000000};
        vecs[5] = '{rs: 4'd15, rt: 4'd15, rd: 4'd8,  wd: 24'h123456, we: 1'b1, exp_rs: 24'hFFFFFF, exp_rt: 24'hFFFFFF};
        vecs[6] = '{rs: 4'd8,  rt: 4'd9,  rd: 4'd0,  wd: 24'h000000, we: 1'b0, exp_rs: 24'h123456, exp_rt: 24'h000007};
        vecs[7] = '{rs: 4'd3,  rt: 4'd0,  rd: 4'd3,  wd: 24'h000000, we: 1'b0, exp_rs: 24'h000000, exp_rt: 24'h000000};

        #3;
        for (int a = 0; a < NUM_REGS; a++) begin
            RS = a[ADDR_W-1:0]; RT = a[ADDR_W-1:0];
            #1;
            check($sformatf("reset_rs[%0d]", a), ReadRS, '0);
            check($sformatf("reset_rt[%0d]", a), ReadRT, '0);
        end
        step();
        ResetN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wd, vecs[i].we);
            #1;
            check($sformatf("vec%0d_rs", i), ReadRS, vecs[i].exp_rs);
            check($sformatf("vec%0d_rt", i), ReadRT, vecs[i].exp_rt);
            step();
        end

        // Same-cycle write/read of R15 with new data: old value before the edge, new value after.
        drive(4'd15, 4'd15, 4'd15, 24'h5A5A5A, 1'b1);
        #1;
        check("same_cycle_before", ReadRS, 24'hFFFFFF);
        step();
        RegWrite = 1'b0;
        #1;
        check("same_cycle_after_rs", ReadRS, 24'h5A5A5A);
        check("same_cycle_after_rt", ReadRT, 24'h5A5A5A);

        // Async reset between edges clears state without a clock edge.
        do_reset();
        drive(4'd8, 4'd9, 4'd8, 24'h000005, 1'b1);
        step();
        drive(4'd8, 4'd9, 4'd9, 24'h000007, 1'b1);
        step();
        RegWrite = 1'b0;
        #1;
        check("preload_r8", ReadRS, 24'h000005);
        check("preload_r9", ReadRT, 24'h000007);
        ResetN = 1'b0;
        #1;
        check("async_rst_rs", ReadRS, '0);
        check("async_rst_rt", ReadRT, '0);
        drive(4'd8, 4'd9, 4'd8, 24'h0000AA, 1'b1);
        step();
        check("rst_blocks_write", ReadRS, '0);
        ResetN = 1'b1;
        drive(4'd4, 4'd8, 4'd4, 24'h000077, 1'b1);
        #1;
        check("post_release_pre_edge", ReadRS, '0);
        step();
        RegWrite = 1'b0;
        #1;
        check("first_write_after_release", ReadRS, 24'h000077);
        check("r8_still_clear", ReadRT, '0);

        // Sweep: R[i] = 0x1000 + i, then read pairs (i, 16-i).
        do_reset();
        for (int i = 1; i < NUM_REGS; i++) begin
            drive('0, '0, i[ADDR_W-1:0], DATA_W'(32'h1000 + i), 1'b1);
            step();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            int j;
            j = (NUM_REGS - i) % NUM_REGS;
            RS = i[ADDR_W-1:0]; RT = j[ADDR_W-1:0];
            #1;
            e = (i == 0) ? '0 : DATA_W'(32'h1000 + i);
            check($sformatf("sweep_rs[%0d]", i), ReadRS, e);
            e = (j == 0) ? '0 : DATA_W'(32'h1000 + j);
            check($sformatf("sweep_rt[%0d]", j), ReadRT, e);
        end

        // Random traffic against the array model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(NUM_REGS - 1), $urandom_range(NUM_REGS - 1), $urandom_range(NUM_REGS - 1),
                  DATA_W'($urandom), ($urandom_range(3) != 0));
            #1;
            check($sformatf("rand%0d_rs", n), ReadRS, model[RS]);
            check($sformatf("rand%0d_rt", n), ReadRT, model[RT]);
            if (RegWrite && RD != 0) model[RD] = WriteData;
            step();
        end
        RegWrite = 1'b0;
        for (int a = 0; a < NUM_REGS; a++) begin
            RS = a[ADDR_W-1:0]; RT = a[ADDR_W-1:0];
            #1;
            check($sformatf("final_rs[%0d]", a), ReadRS, model[a]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file
